// File: rtl/elevator_btn_cond.sv
// rtl/elevator_btn_cond.sv - push-button synchroniser, debouncer, press-pulse and stuck detector
//
// Purpose: conditions the ten raw elevator buttons ahead of the controller.
// Each channel is an independent two-flop synchroniser, then a debouncer
// that accepts a new level only after DEB_CYCLES consecutive samples, then
// a stuck-button timer that counts STUCK_CYCLES.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   btn_raw    raw asynchronous buttons [0]=U1 [1]=U2 [2]=U3 [3]=D2 [4]=D3
//              [5]=D4 [6]=F1 [7]=F2 [8]=F3 [9]=F4, 1 = pressed
//   btn_pulse  one-cycle pulse on each accepted press
//   btn_level  debounced level
//   btn_stuck  button held high for STUCK_CYCLES or more
//   any_stuck  registered OR of btn_stuck

module elevator_btn_cond #(
    parameter int DEB_CYCLES   = 4,
    parameter int STUCK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] btn_raw,
    output logic [9:0] btn_pulse,
    output logic [9:0] btn_level,
    output logic [9:0] btn_stuck,
    output logic       any_stuck
);

    localparam int          N_BTN    = 10;
    localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [15:0] STK_LAST = 16'(STUCK_CYCLES - 1);

    logic [9:0]  sync1_q, sync1_d;
    logic [9:0]  sync2_q, sync2_d;
    logic [9:0]  level_q, level_d;
    logic [9:0]  pulse_q, pulse_d;
    logic [9:0]  stuck_q, stuck_d;
    logic        any_stuck_q, any_stuck_d;
    logic [7:0]  deb_cnt_q [N_BTN];
    logic [7:0]  deb_cnt_d [N_BTN];
    logic [15:0] stk_cnt_q [N_BTN];
    logic [15:0] stk_cnt_d [N_BTN];

    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        level_d     = level_q;
        pulse_d     = '0;
        stuck_d     = stuck_q;
        any_stuck_d = |stuck_q;
        deb_cnt_d   = deb_cnt_q;
        stk_cnt_d   = stk_cnt_q;

        for (int i = 0; i < N_BTN; i++) begin
            // Debounce: count consecutive samples disagreeing with the
            // accepted level; any agreeing sample restarts the count.
            if (sync2_q[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] < DEB_LAST) begin
                deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
            end else begin
                level_d[i]   = sync2_q[i];
                deb_cnt_d[i] = '0;
                pulse_d[i]   = sync2_q[i];
            end

            // Stuck timer runs off the current debounced level and
            // saturates, so the flag holds until the level drops.
            if (!level_q[i]) begin
                stk_cnt_d[i] = '0;
                stuck_d[i]   = 1'b0;
            end else if (stk_cnt_q[i] < STK_LAST) begin
                stk_cnt_d[i] = stk_cnt_q[i] + 16'd1;
            end else begin
                stuck_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            pulse_q     <= '0;
            stuck_q     <= '0;
            any_stuck_q <= 1'b0;
            deb_cnt_q   <= '{default: '0};
            stk_cnt_q   <= '{default: '0};
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            pulse_q     <= pulse_d;
            stuck_q     <= stuck_d;
            any_stuck_q <= any_stuck_d;
            deb_cnt_q   <= deb_cnt_d;
            stk_cnt_q   <= stk_cnt_d;
        end
    end

    assign btn_pulse = pulse_q;
    assign btn_level = level_q;
    assign btn_stuck = stuck_q;
    assign any_stuck = any_stuck_q;

endmodule

// File: tb/tb_elevator_btn_cond.sv
// tb/tb_elevator_btn_cond.sv - self-checking bench for elevator_btn_cond

module tb_elevator_btn_cond;

    localparam int DEB   = 4;
    localparam int STUCK = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] btn_raw = '0;
    logic [9:0] btn_pulse, btn_level, btn_stuck;
    logic       any_stuck;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    elevator_btn_cond #(
        .DEB_CYCLES  (DEB),
        .STUCK_CYCLES(STUCK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level),
        .btn_stuck(btn_stuck),
        .any_stuck(any_stuck)
    );

    always #5 clk = ~clk;

    // Reference model: sync2 is the raw input two edges late; a level is
    // accepted when the last DEB consumed samples all differ from it; stuck
    // is "level has been high for at least STUCK edges".
    logic [9:0]     m_s1 = '0, m_s2 = '0;
    logic [9:0]     m_level = '0, m_pulse = '0, m_stuck = '0;
    logic           m_any = 1'b0;
    logic [DEB-1:0] win [10];
    int             hi_len [10];

    initial begin
        for (int i = 0; i < 10; i++) begin
            win[i]    = '0;
            hi_len[i] = 0;
        end
    end

    always @(posedge clk) begin
        logic [9:0] n_level, n_pulse, n_stuck;
        n_level = m_level;
        n_pulse = '0;
        n_stuck = m_stuck;
        if (rst) begin
            for (int i = 0; i < 10; i++) begin
                win[i]    <= '0;
                hi_len[i] <= 0;
            end
            m_s1 <= '0; m_s2 <= '0;
            m_level <= '0; m_pulse <= '0; m_stuck <= '0; m_any <= 1'b0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                logic [DEB-1:0] w;
                int             h;
                w = {win[i][DEB-2:0], m_s2[i]};
                if (w == (m_level[i] ? {DEB{1'b0}} : {DEB{1'b1}})) begin
                    n_level[i] = ~m_level[i];
                    n_pulse[i] = n_level[i];
                end
                win[i] <= w;
                h = hi_len[i];
                if (!m_level[i]) begin
                    h = 0;
                    n_stuck[i] = 1'b0;
                end else begin
                    if (h < STUCK) h = h + 1;
                    n_stuck[i] = (h >= STUCK);
                end
                hi_len[i] <= h;
            end
            m_any   <= |m_stuck;
            m_level <= n_level;
            m_pulse <= n_pulse;
            m_stuck <= n_stuck;
            m_s2    <= m_s1;
            m_s1    <= btn_raw;
        end
    end

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pulse", btn_pulse, m_pulse);
            chk("model_level", btn_level, m_level);
            chk("model_stuck", btn_stuck, m_stuck);
            chk("model_any",   {9'd0, any_stuck}, {9'd0, m_any});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int bseq [5];
        int cnt, first;
        bseq = '{1, 0, 1, 1, 0};

        // Reset
        tick(3);
        cmp_en = 1'b1;
        chk("rst_pulse", btn_pulse, 10'h000);
        chk("rst_level", btn_level, 10'h000);
        chk("rst_stuck", btn_stuck, 10'h000);
        chk("rst_any",   {9'd0, any_stuck}, 10'h000);
        rst = 1'b0;
        tick(2);

        // Clean press on F2, then release
        btn_raw[7] = 1'b1;
        tick(5);
        chk("press_early", btn_level, 10'h000);
        tick(1);
        chk("press_level", btn_level, 10'h080);
        chk("press_pulse", btn_pulse, 10'h080);
        tick(1);
        chk("press_pulse_drop", btn_pulse, 10'h000);
        chk("press_level_hold", btn_level, 10'h080);
        tick(10);
        btn_raw[7] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick(1);
            chk("release_no_pulse", btn_pulse, 10'h000);
        end
        chk("release_level", btn_level, 10'h000);
        tick(2);

        // Bounce on U1
        for (int k = 0; k < 5; k++) begin
            btn_raw[0] = bseq[k][0];
            tick(1);
            chk("bounce_no_pulse", btn_pulse, 10'h000);
        end
        btn_raw[0] = 1'b1;
        cnt = 0; first = -1;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            if (btn_pulse[0]) begin
                cnt++;
                if (first < 0) first = t;
            end
        end
        chk("bounce_count", 10'(cnt), 10'd1);
        chk("bounce_when", 10'(first), 10'd6);
        btn_raw[0] = 1'b0;
        tick(8);

        // Glitch on D3: three high cycles
        btn_raw[4] = 1'b1;
        tick(3);
        btn_raw[4] = 1'b0;
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            if (btn_level[4] || btn_pulse[4]) cnt++;
        end
        chk("glitch_rejected", 10'(cnt), 10'd0);

        // Stuck on F4
        btn_raw[9] = 1'b1;
        tick(6);
        chk("stuck_press", btn_pulse, 10'h200);
        tick(19);
        chk("stuck_not_yet", btn_stuck, 10'h000);
        tick(1);
        chk("stuck_set", btn_stuck, 10'h200);
        chk("any_lag", {9'd0, any_stuck}, 10'h000);
        tick(1);
        chk("any_set", {9'd0, any_stuck}, 10'h001);
        tick(5);
        btn_raw[9] = 1'b0;
        tick(6);
        chk("stuck_rel_level", btn_level, 10'h000);
        tick(1);
        chk("stuck_clear", btn_stuck, 10'h000);
        tick(1);
        chk("any_clear", {9'd0, any_stuck}, 10'h000);
        btn_raw[9] = 1'b1;
        tick(6);
        chk("stuck_repress", btn_pulse, 10'h200);
        btn_raw[9] = 1'b0;
        tick(8);

        // Reset two edges before the U3 pulse is due
        btn_raw[2] = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("midrst_pulse", btn_pulse, 10'h000);
        chk("midrst_level", btn_level, 10'h000);
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick(1);
            chk("midrst_wait", btn_pulse, 10'h000);
        end
        tick(1);
        chk("midrst_repulse", btn_pulse, 10'h004);
        btn_raw[2] = 1'b0;
        tick(8);

        // All buttons at once
        btn_raw = 10'h3FF;
        tick(6);
        chk("all_pulse", btn_pulse, 10'h3FF);
        tick(1);
        chk("all_pulse_once", btn_pulse, 10'h000);
        btn_raw = 10'h000;
        tick(8);

        // Random traffic, checked every cycle against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 10; i++)
                if ($urandom_range(0, 7) == 0) btn_raw[i] = ~btn_raw[i];
            rst = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        btn_raw = '0;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_btn_cond.md
# elevator_btn_cond

Input conditioning stage placed directly upstream of the elevator controller: takes the ten raw, asynchronous, bouncing push-button signals (hall U1–U3, D2–D4, car F1–F4), synchronises each to clk, debounces it, and emits a clean one-cycle press pulse per button that drives the controller's button inputs. It also reports a debounced level per button and flags buttons held down abnormally long, so a jammed button cannot keep re-registering calls.

## Interface
- DEB_CYCLES, 4: consecutive synchronised samples a new level must hold before it is accepted; legal range 2–255.
- STUCK_CYCLES, 1000: cycles of continuous debounced-high level after which a button is flagged stuck; legal range DEB_CYCLES+1 to 65535.
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  10  raw buttons, asynchronous; bit map [0]=U1 [1]=U2 [2]=U3 [3]=D2 [4]=D3 [5]=D4 [6]=F1 [7]=F2 [8]=F3 [9]=F4; 1 = pressed.
- btn_pulse  output  10  one-cycle pulse on accepted press (rising debounced edge), same bit map; connects to controller U1..F4.
- btn_level  output  10  debounced level, same bit map.
- btn_stuck  output  10  per-button stuck flag.
- any_stuck  output  1  OR of btn_stuck.

## Operation
- Ten identical, fully independent channels; no priority or interaction between bits.
- Per channel: sync1 <= btn_raw[i]; sync2 <= sync1 (two-flop synchroniser, no other logic on sync1).
- Debounce: counter deb_cnt (8 bits).
  - sync2 == btn_level[i]: deb_cnt <= 0.
  - sync2 != btn_level[i] and deb_cnt < DEB_CYCLES-1: deb_cnt <= deb_cnt+1.
  - sync2 != btn_level[i] and deb_cnt == DEB_CYCLES-1: btn_level[i] <= sync2, deb_cnt <= 0; btn_pulse[i] <= 1 if sync2 == 1.
  - btn_pulse[i] is 0 in every other cycle; never two pulses without an accepted release between.
- Release follows the same rule (DEB_CYCLES stable-low samples); release produces no pulse.
- Stuck detection: counter stk_cnt (16 bits), per channel.
  - btn_level[i] == 0: stk_cnt <= 0, btn_stuck[i] <= 0.
  - btn_level[i] == 1 and stk_cnt < STUCK_CYCLES-1: stk_cnt <= stk_cnt+1.
  - btn_level[i] == 1 and stk_cnt == STUCK_CYCLES-1: btn_stuck[i] <= 1, stk_cnt holds (saturates).
  - Stuck flag clears only on accepted release or rst. While stuck, btn_pulse[i] stays 0 (already guaranteed, since level is high).
- any_stuck registered: any_stuck <= |btn_stuck (one cycle behind btn_stuck).

## Timing
- Reset (rst high at a clk edge): sync1, sync2, btn_level, btn_pulse, btn_stuck, any_stuck, deb_cnt, stk_cnt all 0. Reset mid-count discards progress; a button held through reset is re-debounced from zero and does pulse once after reset.
- Press latency: btn_raw[i] rising and stable before edge k → sync2 = 1 after edge k+1 → btn_level[i] and btn_pulse[i] = 1 after edge k+1+DEB_CYCLES (DEB_CYCLES=4: edge k+5). btn_pulse[i] drops after the next edge.
- Release latency identical: btn_level[i] = 0 after edge k+1+DEB_CYCLES.
- Glitch rule: any sync2 run shorter than DEB_CYCLES samples in the non-current level is rejected with no output change; a single return sample resets deb_cnt to 0.
- Stuck: btn_stuck[i] = 1 after STUCK_CYCLES edges with btn_level[i]=1 (counted from the edge that raised btn_level); any_stuck one edge later.
- Simultaneous presses on several bits: each bit pulses in its own cycle per the above; coincident pulses allowed.

## Test plan
- Clean press, DEB_CYCLES=4: btn_raw[7] 0→1 before edge 10, held 20 cycles → btn_level[7]=1 and single btn_pulse[7] after edge 15, pulse gone after edge 16; release → btn_level[7]=0 after 5 edges, no pulse.
- Bounce: btn_raw[0] toggles 1,0,1,1,0 per cycle then stays 1 → no pulse during bounce; exactly one pulse 5 edges after final stable 1 sampled.
- Glitch: btn_raw[4] high for 3 cycles only → btn_level and btn_pulse stay 0 throughout.
- Stuck, STUCK_CYCLES=20: btn_raw[9] held high → btn_stuck[9]=1 20 edges after btn_level rises, any_stuck one edge later; release → both 0 after debounce, new press pulses normally.
- Reset mid-operation: btn_raw[2] held, rst asserted 2 edges before pulse due → no pulse, all outputs 0; rst released with button held → one pulse 5 edges after first post-reset sample.
- Simultaneous: btn_raw = 10'h3FF in one cycle → all ten btn_pulse bits 1 in the same cycle, once.
